alu_sliced: RTL and testbench



---
 rtl/alu_sliced.sv | 153 +++++++++++++++
 tb/tb_alu_sliced.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sliced.sv
// Multi-cycle sliced ALU: WIDTH-bit operands processed SLICE bits per clock,
// LSB slice first, through a carry-chained slice datapath with START/BUSY/DONE.
//
// state | meaning
// IDLE  | waiting for START; result registers hold the last completion
// RUN   | one slice per clock, cnt selects the slice, carry chains between slices
// FIN   | DONE pulse; START here is accepted back-to-back
module alu_sliced #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       FUNC,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT,
  output logic             C_OUT,
  output logic             Z,
  output logic             V
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] F_SUB  = 3'b000;
  localparam logic [2:0] F_XOR  = 3'b001;
  localparam logic [2:0] F_PASA = 3'b010;
  localparam logic [2:0] F_PASB = 3'b011;
  localparam logic [2:0] F_ADD  = 3'b100;
  localparam logic [2:0] F_AND  = 3'b101;
  localparam logic [2:0] F_OR   = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [2:0]       func_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] x_s;
  logic [SLICE-1:0] y_s;
  logic [SLICE-1:0] res_s;
  logic [SLICE:0]   sum_s;
  logic             carry_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic             is_sub;
  logic             is_add;
  logic             v_nxt;
  logic             c_nxt;
  int               idx;

  // SUB is formed as ~(B + ~A + carry) so both arithmetic modes share one adder.
  always_comb begin
    idx    = int'(cnt) * SLICE;
    a_s    = a_q[idx +: SLICE];
    b_s    = b_q[idx +: SLICE];
    is_sub = (func_q == F_SUB);
    is_add = (func_q == F_ADD);
    x_s    = is_sub ? b_s : a_s;
    y_s    = is_sub ? ~a_s : b_s;
    sum_s  = {1'b0, x_s} + {1'b0, y_s} + {{SLICE{1'b0}}, carry};
    carry_nxt = sum_s[SLICE];
    case (func_q)
      F_SUB:   res_s = ~sum_s[SLICE-1:0];
      F_XOR:   res_s = a_s ^ b_s;
      F_PASA:  res_s = a_s;
      F_PASB:  res_s = b_s;
      F_ADD:   res_s = sum_s[SLICE-1:0];
      F_AND:   res_s = a_s & b_s;
      F_OR:    res_s = a_s | b_s;
      default: res_s = b_s;
    endcase
    acc_nxt = acc;
    acc_nxt[idx +: SLICE] = res_s;
  end

  // Flags are only meaningful on the last slice, when acc_nxt holds the full result.
  always_comb begin
    v_nxt = 1'b0;
    if (is_add)
      v_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
    else if (is_sub)
      v_nxt = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
    c_nxt = (is_add || is_sub) && carry_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      OUT    <= '0;
      C_OUT  <= 1'b0;
      Z      <= 1'b0;
      V      <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
      acc    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      func_q <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (START) begin
            a_q    <= A;
            b_q    <= B;
            func_q <= FUNC;
            carry  <= C_IN;
            cnt    <= '0;
            BUSY   <= 1'b1;
            state  <= RUN;
          end else begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= carry_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            OUT   <= acc_nxt;
            C_OUT <= c_nxt;
            Z     <= (acc_nxt == '0);
            V     <= v_nxt;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sliced.sv
// Directed and randomised checks of alu_sliced in three slice configurations.
module tb_alu_sliced;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        START, C_IN, BUSY, DONE, C_OUT, Z, V;
  logic [2:0]  FUNC;
  logic [15:0] A, B, OUT;

  logic        s8_start, s8_cin, s8_busy, s8_done, s8_cout, s8_z, s8_v;
  logic [2:0]  s8_func;
  logic [7:0]  s8_a, s8_b, s8_out;

  logic        s32_start, s32_cin, s32_busy, s32_done, s32_cout, s32_z, s32_v;
  logic [2:0]  s32_func;
  logic [31:0] s32_a, s32_b, s32_out;

  int errors = 0;
  int checks = 0;

  alu_sliced #(.WIDTH(16), .SLICE(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .FUNC(FUNC), .A(A), .B(B), .C_IN(C_IN),
    .BUSY(BUSY), .DONE(DONE), .OUT(OUT), .C_OUT(C_OUT), .Z(Z), .V(V));

  alu_sliced #(.WIDTH(8), .SLICE(8)) dut8 (
    .CLK(CLK), .RST(RST), .START(s8_start), .FUNC(s8_func), .A(s8_a), .B(s8_b), .C_IN(s8_cin),
    .BUSY(s8_busy), .DONE(s8_done), .OUT(s8_out), .C_OUT(s8_cout), .Z(s8_z), .V(s8_v));

  alu_sliced #(.WIDTH(32), .SLICE(1)) dut32 (
    .CLK(CLK), .RST(RST), .START(s32_start), .FUNC(s32_func), .A(s32_a), .B(s32_b), .C_IN(s32_cin),
    .BUSY(s32_busy), .DONE(s32_done), .OUT(s32_out), .C_OUT(s32_cout), .Z(s32_z), .V(s32_v));

  // Whole-word reference: SUB as plain subtraction with borrow, ADD with carry.
  function automatic void ref_op(input int w, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic ci, output logic [31:0] o,
                                 output logic co, output logic z, output logic v);
    logic [63:0] mask, aa, bb, r;
    logic ma, mb, mr;
    mask = (64'd1 << w) - 64'd1;
    aa = {32'd0, a} & mask;
    bb = {32'd0, b} & mask;
    co = 1'b0;
    v  = 1'b0;
    case (f)
      3'd0: begin
        r  = (aa - bb - {63'd0, ci}) & mask;
        co = (aa < bb + {63'd0, ci});
      end
      3'd1: r = aa ^ bb;
      3'd2: r = aa;
      3'd3: r = bb;
      3'd4: begin
        r  = aa + bb + {63'd0, ci};
        co = r[w];
        r  = r & mask;
      end
      3'd5: r = aa & bb;
      3'd6: r = aa | bb;
      default: r = bb;
    endcase
    ma = aa[w-1];
    mb = bb[w-1];
    mr = r[w-1];
    if (f == 3'd4) v = (ma == mb) && (mr != ma);
    if (f == 3'd0) v = (ma != mb) && (mr != ma);
    o = r[31:0];
    z = (r == 64'd0);
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, output int lat);
    @(negedge CLK);
    FUNC = f; A = a; B = b; C_IN = ci; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    lat = 1;
    while (DONE !== 1'b1 && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    if (DONE !== 1'b1) begin
      checks++; errors++;
      $display("FAIL run_op_timeout: DONE=%b after %0d cycles, required 1", DONE, lat);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; FUNC = 3'd0; A = '0; B = '0; C_IN = 1'b0;
    s8_start = 1'b0; s8_func = '0; s8_a = '0; s8_b = '0; s8_cin = 1'b0;
    s32_start = 1'b0; s32_func = '0; s32_a = '0; s32_b = '0; s32_cin = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
    checks++; if (OUT !== 16'h0) begin errors++; $display("FAIL reset_out: got %h want 0000", OUT); end
    checks++; if ({C_OUT, Z, V} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {C_OUT, Z, V}); end
    RST = 1'b0;
  endtask

  task automatic test_sub_basic();
    @(negedge CLK);
    FUNC = 3'b000; A = 16'h1234; B = 16'h0235; C_IN = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
        errors++; $display("FAIL sub_busy_cycle%0d: busy=%b done=%b want busy=1 done=0", i, BUSY, DONE);
      end
      @(negedge CLK);
    end
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL sub_done_latency: done=%b busy=%b want 1/0", DONE, BUSY); end
    checks++; if (OUT !== 16'h0FFF) begin errors++; $display("FAIL sub_basic_out: got %h want 0fff", OUT); end
    checks++; if ({C_OUT, Z, V} !== 3'b000) begin errors++; $display("FAIL sub_basic_flags: got %b want 000", {C_OUT, Z, V}); end
    @(negedge CLK);
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", DONE); end
  endtask

  task automatic test_sub_flags();
    int lat;
    run_op(3'b000, 16'h0000, 16'h0001, 1'b0, lat);
    checks++; if (OUT !== 16'hFFFF || C_OUT !== 1'b1 || V !== 1'b0)
      begin errors++; $display("FAIL sub_borrow: got %h c=%b v=%b want ffff c=1 v=0", OUT, C_OUT, V); end
    run_op(3'b000, 16'h8000, 16'h0001, 1'b0, lat);
    checks++; if (OUT !== 16'h7FFF || C_OUT !== 1'b0 || V !== 1'b1)
      begin errors++; $display("FAIL sub_overflow: got %h c=%b v=%b want 7fff c=0 v=1", OUT, C_OUT, V); end
    run_op(3'b000, 16'h0005, 16'h0004, 1'b1, lat);
    checks++; if (OUT !== 16'h0000 || Z !== 1'b1 || C_OUT !== 1'b0)
      begin errors++; $display("FAIL sub_cin_zero: got %h z=%b c=%b want 0000 z=1 c=0", OUT, Z, C_OUT); end
  endtask

  task automatic test_add_logic();
    int lat;
    run_op(3'b100, 16'hFFFF, 16'h0001, 1'b0, lat);
    checks++; if (OUT !== 16'h0000 || {C_OUT, Z, V} !== 3'b110)
      begin errors++; $display("FAIL add_carry: got %h czv=%b want 0000 czv=110", OUT, {C_OUT, Z, V}); end
    run_op(3'b100, 16'h7FFF, 16'h0001, 1'b0, lat);
    checks++; if (OUT !== 16'h8000 || {C_OUT, Z, V} !== 3'b001)
      begin errors++; $display("FAIL add_overflow: got %h czv=%b want 8000 czv=001", OUT, {C_OUT, Z, V}); end
    run_op(3'b001, 16'hA5A5, 16'hA5A5, 1'b1, lat);
    checks++; if (OUT !== 16'h0000 || {C_OUT, Z, V} !== 3'b010)
      begin errors++; $display("FAIL xor_zero: got %h czv=%b want 0000 czv=010", OUT, {C_OUT, Z, V}); end
    run_op(3'b101, 16'hF0F0, 16'h3C3C, 1'b0, lat);
    checks++; if (OUT !== 16'h3030) begin errors++; $display("FAIL and: got %h want 3030", OUT); end
    run_op(3'b110, 16'h0F00, 16'h00F0, 1'b0, lat);
    checks++; if (OUT !== 16'h0FF0) begin errors++; $display("FAIL or: got %h want 0ff0", OUT); end
    run_op(3'b010, 16'h1234, 16'h5678, 1'b1, lat);
    checks++; if (OUT !== 16'h1234 || C_OUT !== 1'b0) begin errors++; $display("FAIL pass_a: got %h c=%b want 1234 c=0", OUT, C_OUT); end
    run_op(3'b011, 16'h1234, 16'h5678, 1'b0, lat);
    checks++; if (OUT !== 16'h5678) begin errors++; $display("FAIL pass_b: got %h want 5678", OUT); end
    run_op(3'b111, 16'h1234, 16'h9ABC, 1'b0, lat);
    checks++; if (OUT !== 16'h9ABC) begin errors++; $display("FAIL pass_b_reserved: got %h want 9abc", OUT); end
  endtask

  task automatic test_back_to_back();
    int n_done, first, last;
    n_done = 0; first = 0; last = 0;
    @(negedge CLK);
    FUNC = 3'b000; A = 16'h0003; B = 16'h0001; C_IN = 1'b0; START = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        n_done++;
        if (first == 0) first = i;
        last = i;
      end
      if (i == 15) START = 1'b0;
    end
    checks++; if (n_done != 3 || first != 5 || last != 15)
      begin errors++; $display("FAIL back_to_back: dones=%0d first=%0d last=%0d want 3/5/15", n_done, first, last); end
    checks++; if (OUT !== 16'h0002) begin errors++; $display("FAIL back_to_back_out: got %h want 0002", OUT); end
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL back_to_back_idle: busy=%b want 0", BUSY); end
  endtask

  task automatic test_ignore_start();
    int lat, extra;
    @(negedge CLK);
    FUNC = 3'b100; A = 16'h0001; B = 16'h0002; C_IN = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    FUNC = 3'b000; A = 16'h0100; B = 16'h0200; C_IN = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    lat = 0;
    while (DONE !== 1'b1 && lat < 20) begin @(negedge CLK); lat++; end
    checks++; if (DONE !== 1'b1 || OUT !== 16'h0003 || C_OUT !== 1'b0)
      begin errors++; $display("FAIL ignore_start: done=%b out=%h c=%b want 1 0003 0", DONE, OUT, C_OUT); end
    extra = 0;
    repeat (8) begin @(negedge CLK); if (DONE === 1'b1 || BUSY === 1'b1) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL no_queue: %0d busy/done cycles want 0", extra); end
  endtask

  task automatic test_hold();
    int lat;
    @(negedge CLK);
    FUNC = 3'b100; A = 16'h0010; B = 16'h0020; C_IN = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    checks++; if (OUT !== 16'h0003 || BUSY !== 1'b1)
      begin errors++; $display("FAIL hold_during_run: out=%h busy=%b want 0003 1", OUT, BUSY); end
    lat = 0;
    while (DONE !== 1'b1 && lat < 20) begin @(negedge CLK); lat++; end
    checks++; if (OUT !== 16'h0030) begin errors++; $display("FAIL hold_new: got %h want 0030", OUT); end
    repeat (4) @(negedge CLK);
    checks++; if (OUT !== 16'h0030) begin errors++; $display("FAIL hold_idle: got %h want 0030", OUT); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge CLK);
    FUNC = 3'b000; A = 16'h1234; B = 16'h0235; C_IN = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0 || OUT !== 16'h0 || {C_OUT, Z, V} !== 3'b000)
      begin errors++; $display("FAIL reset_mid_run: busy=%b done=%b out=%h czv=%b want 0 0 0000 000", BUSY, DONE, OUT, {C_OUT, Z, V}); end
    RST = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge CLK); if (DONE === 1'b1 || BUSY === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL reset_abort: %0d busy/done cycles want 0", seen); end
    FUNC = 3'b100; A = 16'h0001; B = 16'h0001; START = 1'b1; RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; START = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge CLK); if (DONE === 1'b1 || BUSY === 1'b1) seen++; end
    checks++; if (seen != 0 || OUT !== 16'h0)
      begin errors++; $display("FAIL reset_over_start: %0d busy/done cycles out=%h want 0 0000", seen, OUT); end
  endtask

  task automatic test_random16();
    logic [31:0] eo; logic ec, ez, ev; int lat;
    logic [2:0] f; logic [15:0] a, b; logic ci;
    for (int i = 0; i < 1000; i++) begin
      f = 3'($urandom_range(0, 7)); a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
      run_op(f, a, b, ci, lat);
      ref_op(16, f, {16'd0, a}, {16'd0, b}, ci, eo, ec, ez, ev);
      checks++;
      if (lat != 5 || OUT !== eo[15:0] || C_OUT !== ec || Z !== ez || V !== ev) begin
        errors++;
        $display("FAIL rand16 f=%0d a=%h b=%h ci=%b: got %h czv=%b%b%b lat=%0d want %h czv=%b%b%b lat=5",
                 f, a, b, ci, OUT, C_OUT, Z, V, lat, eo[15:0], ec, ez, ev);
      end
    end
  endtask

  task automatic test_sweep8();
    logic [31:0] eo; logic ec, ez, ev; int lat;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      s8_func = 3'($urandom_range(0, 7)); s8_a = 8'($urandom); s8_b = 8'($urandom);
      s8_cin = 1'($urandom); s8_start = 1'b1;
      if (i == 0) begin s8_func = 3'b100; s8_a = 8'h7F; s8_b = 8'h01; s8_cin = 1'b0; end
      @(negedge CLK);
      s8_start = 1'b0;
      lat = 1;
      while (s8_done !== 1'b1 && lat < 6) begin @(negedge CLK); lat++; end
      ref_op(8, s8_func, {24'd0, s8_a}, {24'd0, s8_b}, s8_cin, eo, ec, ez, ev);
      checks++;
      if (lat != 2 || s8_out !== eo[7:0] || s8_cout !== ec || s8_z !== ez || s8_v !== ev) begin
        errors++;
        $display("FAIL sweep8 f=%0d a=%h b=%h ci=%b: got %h czv=%b%b%b lat=%0d want %h czv=%b%b%b lat=2",
                 s8_func, s8_a, s8_b, s8_cin, s8_out, s8_cout, s8_z, s8_v, lat, eo[7:0], ec, ez, ev);
      end
    end
  endtask

  task automatic test_sweep32();
    logic [31:0] eo; logic ec, ez, ev; int lat;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      s32_func = 3'($urandom_range(0, 7)); s32_a = $urandom; s32_b = $urandom;
      s32_cin = 1'($urandom); s32_start = 1'b1;
      if (i == 0) begin s32_func = 3'b000; s32_a = 32'h0; s32_b = 32'h1; s32_cin = 1'b0; end
      @(negedge CLK);
      s32_start = 1'b0;
      lat = 1;
      while (s32_done !== 1'b1 && lat < 40) begin @(negedge CLK); lat++; end
      ref_op(32, s32_func, s32_a, s32_b, s32_cin, eo, ec, ez, ev);
      checks++;
      if (lat != 33 || s32_out !== eo || s32_cout !== ec || s32_z !== ez || s32_v !== ev) begin
        errors++;
        $display("FAIL sweep32 f=%0d a=%h b=%h ci=%b: got %h czv=%b%b%b lat=%0d want %h czv=%b%b%b lat=33",
                 s32_func, s32_a, s32_b, s32_cin, s32_out, s32_cout, s32_z, s32_v, lat, eo, ec, ez, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub_basic();
    test_sub_flags();
    test_add_logic();
    test_back_to_back();
    test_ignore_start();
    test_hold();
    test_reset_mid();
    test_random16();
    test_sweep8();
    test_sweep32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
